// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared state encoding, stall lengths and default sizes
// for the 4-stage pipeline controller.
package pipe_ctrl_pkg;
    typedef enum logic [1:0] {INIT = 2'd0, RUN = 2'd1, STALL = 2'd2} pipeState_t;
    localparam int REG_AW_DEF = 6;
    localparam int INIT_CYCLES_DEF = 3;
    localparam logic [1:0] STALL_EX = 2'd2;
    localparam logic [1:0] STALL_WB = 2'd1;
endpackage

// File: rtl/pipeline_controller_hazard.sv
// hazard_compare: flags when a register-writing older instruction targets
// a source register actually read by the ID-stage instruction.
module hazard_compare
    import pipe_ctrl_pkg::*;
#(
    parameter int AW = REG_AW_DEF
) (
    input  logic [AW-1:0] rs,
    input  logic [AW-1:0] rt,
    input  logic          rsUsed,
    input  logic          rtUsed,
    input  logic [AW-1:0] rd,
    input  logic          regWrt,
    output logic          hit
);
    assign hit = regWrt && ((rsUsed && rs == rd) || (rtUsed && rt == rd));
endmodule

// File: rtl/pipeline_controller.sv
// pipeline_controller: PC/buffer enables and flushes for IF-ID-EX-WB, with RAW stalls,
// WB redirect squash and post-reset clear. Define PIPE_PERF_EN for performance counters.
module pipeline_controller
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_AW      = REG_AW_DEF,
    parameter int INIT_CYCLES = INIT_CYCLES_DEF,
    parameter bit WB_BYPASS   = 1'b0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_rs_used,
    input  logic              id_rt_used,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              ex_regwrt,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic              wb_regwrt,
    input  logic              wb_redirect,
    output logic              pc_en,
    output logic              ifid_en,
    output logic              ifid_flush,
    output logic              idex_flush,
    output logic              exwb_flush,
`ifdef PIPE_PERF_EN
    output logic [31:0]       stall_cycles,
    output logic [31:0]       flush_events,
    output logic [31:0]       bubble_cycles,
`endif
    output logic              stalled
);
    localparam int ICW = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
    localparam logic [1:0] sInit  = INIT;
    localparam logic [1:0] sRun   = RUN;
    localparam logic [1:0] sStall = STALL;

    logic [1:0]     state, nextState;
    logic [ICW-1:0] initCnt, nextInitCnt;
    logic [1:0]     stallCnt, nextStallCnt;
    logic           exHit, wbHit, hazEx, hazWb, inInit, inRun, inStall, redirect;

    hazard_compare #(.AW(REG_AW)) exCmp (
        .rs(id_rs), .rt(id_rt), .rsUsed(id_rs_used), .rtUsed(id_rt_used),
        .rd(ex_rd), .regWrt(ex_regwrt), .hit(exHit)
    );
    hazard_compare #(.AW(REG_AW)) wbCmp (
        .rs(id_rs), .rt(id_rt), .rsUsed(id_rs_used), .rtUsed(id_rt_used),
        .rd(wb_rd), .regWrt(wb_regwrt), .hit(wbHit)
    );

    // A write-before-read register file already sees the WB result in ID.
    assign hazEx = exHit;
    assign hazWb = WB_BYPASS ? 1'b0 : wbHit;

    always_comb begin
        inInit       = state == sInit;
        inRun        = state == sRun;
        inStall      = state == sStall;
        redirect     = wb_redirect && !inInit;
        pc_en        = redirect || (inRun && !hazEx && !hazWb);
        ifid_en      = redirect || (inRun && !hazEx && !hazWb);
        ifid_flush   = inInit || redirect;
        exwb_flush   = inInit || redirect;
        idex_flush   = inInit || redirect || inStall || (inRun && (hazEx || hazWb));
        stalled      = inStall && !redirect;
        nextState    = state;
        nextInitCnt  = initCnt;
        nextStallCnt = stallCnt;
        if (inInit) begin
            nextState   = (initCnt == '0) ? sRun : sInit;
            nextInitCnt = (initCnt == '0) ? initCnt : initCnt - 1'b1;
        end else if (redirect) begin
            nextState    = sRun;
            nextStallCnt = 2'd0;
        end else if (inRun && hazEx) begin
            nextState    = sStall;
            nextStallCnt = STALL_EX;
        end else if (inRun && hazWb) begin
            nextState    = sStall;
            nextStallCnt = STALL_WB;
        end else if (inStall) begin
            nextState    = (stallCnt <= 2'd1) ? sRun : sStall;
            nextStallCnt = (stallCnt <= 2'd1) ? 2'd0 : stallCnt - 2'd1;
        end else if (!inRun) begin
            nextState = sInit;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= sInit;
            initCnt  <= ICW'(INIT_CYCLES - 1);
            stallCnt <= 2'd0;
        end else begin
            state    <= nextState;
            initCnt  <= nextInitCnt;
            stallCnt <= nextStallCnt;
        end
    end

`ifdef PIPE_PERF_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stall_cycles  <= 32'd0;
            flush_events  <= 32'd0;
            bubble_cycles <= 32'd0;
        end else begin
            stall_cycles  <= stall_cycles + 32'(stalled);
            flush_events  <= flush_events + 32'(redirect);
            bubble_cycles <= bubble_cycles + 32'(idex_flush && !inInit);
        end
    end
`endif
endmodule
